// File: rtl/s3g_packet_tx.sv
// s3g_packet_tx: frames a payload buffer into a UART byte stream.
// Frame: 0xD5, length byte, payload[0..len-1], CRC-8/MAXIM of the payload.
// Ports:
//   clk, rst          - rising-edge clock, async active-low reset
//   buf_wr/addr/data  - payload buffer write port (ignored while busy)
//   payload_len       - byte count, sampled with packet_wr
//   packet_wr         - start pulse (ignored while busy)
//   busy              - packet in progress
//   packet_sent       - one-cycle pulse after the CRC byte completes
//   len_err           - one-cycle pulse when payload_len exceeds MAX_LEN
//   tx_data, tx_wr    - byte and one-cycle write strobe to the UART
//   tx_done           - UART pulse, previous byte finished
module s3g_packet_tx #(
  parameter int unsigned MAX_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       buf_wr,
  input  logic [$clog2(MAX_LEN)-1:0] buf_addr,
  input  logic [7:0]                 buf_data,
  input  logic [7:0]                 payload_len,
  input  logic                       packet_wr,
  output logic                       busy,
  output logic                       packet_sent,
  output logic                       len_err,
  output logic [7:0]                 tx_data,
  output logic                       tx_wr,
  input  logic                       tx_done
);

  localparam int unsigned AW        = $clog2(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]  SYNC_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // One byte step of CRC-8/MAXIM, reflected polynomial 0x8C
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  logic [7:0] r_buf [MAX_LEN];

  state_t     r_state, w_state_nxt;
  logic       r_busy, r_tx_wr, r_packet_sent, r_len_err;
  logic [7:0] r_tx_data, r_len, r_cnt, r_crc;

  logic       w_busy_nxt, w_tx_wr_nxt, w_sent_nxt, w_err_nxt;
  logic [7:0] w_tx_data_nxt, w_len_nxt, w_cnt_nxt, w_crc_nxt;

  // A tx_done coincident with our own strobe cannot be the end of that byte
  logic          w_done;
  logic          w_accept;
  logic          w_reject;
  logic [7:0]    w_cnt_inc;
  logic          w_last;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_byte;

  assign w_done    = tx_done & ~r_tx_wr;
  assign w_accept  = packet_wr & (payload_len <= MAX_LEN_B);
  assign w_reject  = packet_wr & (payload_len > MAX_LEN_B);
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_last    = (w_cnt_inc == r_len);

  // Asynchronous read of the next byte so it is ready on the tx_done edge
  assign w_rd_addr = (r_state == LEN) ? '0 : w_cnt_inc[AW-1:0];
  assign w_rd_byte = r_buf[w_rd_addr];

  // Payload buffer: written only while idle, never reset
  always_ff @(posedge clk) begin
    if (buf_wr && !r_busy) begin
      r_buf[buf_addr] <= buf_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)          w_state_nxt = SYNC;
      SYNC:    if (w_done)            w_state_nxt = LEN;
      LEN:     if (w_done)            w_state_nxt = (r_len != 8'd0) ? PAYLOAD : CRC;
      PAYLOAD: if (w_done && w_last)  w_state_nxt = CRC;
      CRC:     if (w_done)            w_state_nxt = FINISH;
      FINISH:                         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; the byte for each state is loaded on entry
  always_comb begin
    w_tx_wr_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_busy_nxt    = r_busy;
    w_sent_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_crc_nxt     = r_crc;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tx_wr_nxt   = 1'b1;
          w_tx_data_nxt = SYNC_BYTE;
          w_busy_nxt    = 1'b1;
          w_len_nxt     = payload_len;
          w_cnt_nxt     = 8'd0;
          w_crc_nxt     = 8'h00;
        end else if (w_reject) begin
          w_err_nxt = 1'b1;
        end
      end
      SYNC: begin
        if (w_done) begin
          w_tx_wr_nxt   = 1'b1;
          w_tx_data_nxt = r_len;
        end
      end
      LEN: begin
        if (w_done) begin
          w_tx_wr_nxt = 1'b1;
          w_cnt_nxt   = 8'd0;
          if (r_len != 8'd0) begin
            w_tx_data_nxt = w_rd_byte;
            w_crc_nxt     = crc8_byte(r_crc, w_rd_byte);
          end else begin
            w_tx_data_nxt = r_crc;
          end
        end
      end
      PAYLOAD: begin
        if (w_done) begin
          w_tx_wr_nxt = 1'b1;
          if (w_last) begin
            w_tx_data_nxt = r_crc;
          end else begin
            w_cnt_nxt     = w_cnt_inc;
            w_tx_data_nxt = w_rd_byte;
            w_crc_nxt     = crc8_byte(r_crc, w_rd_byte);
          end
        end
      end
      CRC: begin
        if (w_done) begin
          w_sent_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end
      end
      FINISH: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy        <= 1'b0;
      r_tx_wr       <= 1'b0;
      r_packet_sent <= 1'b0;
      r_len_err     <= 1'b0;
      r_tx_data     <= 8'h00;
      r_len         <= 8'h00;
      r_cnt         <= 8'h00;
      r_crc         <= 8'h00;
    end else begin
      r_busy        <= w_busy_nxt;
      r_tx_wr       <= w_tx_wr_nxt;
      r_packet_sent <= w_sent_nxt;
      r_len_err     <= w_err_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_len         <= w_len_nxt;
      r_cnt         <= w_cnt_nxt;
      r_crc         <= w_crc_nxt;
    end
  end

  assign busy        = r_busy;
  assign tx_wr       = r_tx_wr;
  assign packet_sent = r_packet_sent;
  assign len_err     = r_len_err;
  assign tx_data     = r_tx_data;

endmodule

// File: tb/tb_s3g_packet_tx.sv
// Testbench for s3g_packet_tx: table of packets plus directed corner sequences.
// A UART model pops expected bytes from a scoreboard queue on every tx_wr and
// answers with tx_done after a per-packet delay.
module tb_s3g_packet_tx;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned AW      = $clog2(MAX_LEN);

  logic          clk;
  logic          rst;
  logic          buf_wr;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic [7:0]    payload_len;
  logic          packet_wr;
  logic          busy;
  logic          packet_sent;
  logic          len_err;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_done;

  logic u_done;   // from the UART model
  logic x_done;   // stray pulses from directed sequences
  assign tx_done = u_done | x_done;

  s3g_packet_tx #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_wr      (buf_wr),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .payload_len (payload_len),
    .packet_wr   (packet_wr),
    .busy        (busy),
    .packet_sent (packet_sent),
    .len_err     (len_err),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } sb_t;

  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] exp_crc;
    bit         use_model;
    int         dly;
  } vec_t;

  sb_t        sb[$];
  logic [7:0] mem [MAX_LEN];
  int         n_pass  = 0;
  int         n_total = 0;
  int         dly     = 2;
  int         wait_cnt;
  bit         last_issued;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference CRC-8/MAXIM over mem[0..len-1]
  function automatic logic [7:0] crc_model(input int len);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < len; i++) begin
      c = c ^ mem[i];
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_buf(input int a, input logic [7:0] d);
    buf_wr   = 1'b1;
    buf_addr = AW'(a);
    buf_data = d;
    tick();
    buf_wr   = 1'b0;
  endtask

  task automatic push_pkt(input int len, input logic [7:0] crc);
    sb.push_back('{8'hD5, 1'b0});
    sb.push_back('{8'(len), 1'b0});
    for (int i = 0; i < len; i++) sb.push_back('{mem[i], 1'b0});
    sb.push_back('{crc, 1'b1});
  endtask

  // Pulse packet_wr, optionally with a same-cycle write of buffer[0]
  task automatic start_pkt(input int len, input bit wr0, input logic [7:0] d0);
    payload_len = 8'(len);
    packet_wr   = 1'b1;
    if (wr0) begin
      buf_wr   = 1'b1;
      buf_addr = '0;
      buf_data = d0;
    end
    tick();
    packet_wr = 1'b0;
    buf_wr    = 1'b0;
    check("start_tx_wr", 32'(tx_wr), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_sent(input string name);
    int n;
    n = 0;
    while (!packet_sent && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_sent"}, 32'(packet_sent), 32'd1);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    tick();
    check({name, "_sent_pulse_end"}, 32'(packet_sent), 32'd0);
    check({name, "_all_bytes"}, 32'(sb.size()), 32'd0);
  endtask

  // UART model / scoreboard consumer, sampled on the falling edge
  initial begin
    bit  prev;
    sb_t e;
    u_done      = 1'b0;
    wait_cnt    = 0;
    last_issued = 1'b0;
    forever begin
      @(negedge clk);
      prev   = u_done;
      u_done = 1'b0;
      if (rst) begin
        if (prev) begin
          if (last_issued) begin
            check("sent_after_crc_done", 32'(packet_sent), 32'd1);
            check("busy_after_crc_done", 32'(busy), 32'd0);
          end else begin
            check("b2b_tx_wr", 32'(tx_wr), 32'd1);
          end
        end
        if (tx_wr) begin
          if (sb.size() == 0) begin
            check("extra_tx_wr", 32'(tx_wr), 32'd0);
          end else begin
            e = sb.pop_front();
            check("tx_byte", 32'(tx_data), 32'(e.b));
            last_issued = e.last;
          end
          wait_cnt = dly;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) u_done = 1'b1;
        end
      end
    end
  end

  vec_t vecs[6];

  initial begin
    logic [7:0] exp;
    vecs[0] = '{1,  8'h01, 8'h00, 8'h5E, 1'b0, 10};
    vecs[1] = '{9,  8'h31, 8'h01, 8'hA1, 1'b0, 3};
    vecs[2] = '{0,  8'h00, 8'h00, 8'h00, 1'b0, 3};
    vecs[3] = '{32, 8'h00, 8'h01, 8'h00, 1'b1, 2};
    vecs[4] = '{5,  8'hA5, 8'h3B, 8'h00, 1'b1, 1};
    vecs[5] = '{2,  8'hFF, 8'h01, 8'h00, 1'b1, 6};

    rst = 1'b0; buf_wr = 1'b0; buf_addr = '0; buf_data = 8'h00;
    payload_len = 8'h00; packet_wr = 1'b0; x_done = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_sent", 32'(packet_sent), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    tick();

    // Table of packets
    for (int v = 0; v < 6; v++) begin
      dly = vecs[v].dly;
      for (int i = 0; i < vecs[v].len; i++) begin
        mem[i] = vecs[v].base + 8'(i) * vecs[v].step;
        wr_buf(i, mem[i]);
      end
      exp = vecs[v].use_model ? crc_model(vecs[v].len) : vecs[v].exp_crc;
      push_pkt(vecs[v].len, exp);
      start_pkt(vecs[v].len, 1'b0, 8'h00);
      wait_sent($sformatf("vec%0d", v));
    end

    // Oversize lengths are rejected with a single len_err pulse
    for (int k = 0; k < 2; k++) begin
      payload_len = (k == 0) ? 8'd33 : 8'd255;
      packet_wr   = 1'b1;
      tick();
      packet_wr = 1'b0;
      check("len_err_pulse", 32'(len_err), 32'd1);
      check("len_err_busy", 32'(busy), 32'd0);
      check("len_err_tx_wr", 32'(tx_wr), 32'd0);
      tick();
      check("len_err_end", 32'(len_err), 32'd0);
      repeat (5) tick();
      check("len_err_idle", 32'(busy), 32'd0);
    end

    // packet_wr and buf_wr while busy are ignored; buffer persists for resend
    dly    = 4;
    mem[0] = 8'h02;
    wr_buf(0, 8'h02);
    push_pkt(1, 8'hBC);
    start_pkt(1, 1'b0, 8'h00);
    tick(); tick();
    payload_len = 8'd1; packet_wr = 1'b1;
    buf_wr = 1'b1; buf_addr = '0; buf_data = 8'hFF;
    tick();
    packet_wr = 1'b0; buf_wr = 1'b0;
    wait_sent("midpkt");
    repeat (20) tick();
    check("midpkt_not_queued", 32'(busy), 32'd0);
    push_pkt(1, 8'hBC);
    start_pkt(1, 1'b0, 8'h00);
    wait_sent("resend");

    // Same-cycle buf_wr and packet_wr: the new byte is sent
    mem[0] = 8'h7E;
    push_pkt(1, crc_model(1));
    start_pkt(1, 1'b1, 8'h7E);
    wait_sent("same_cycle_wr");

    // Stray tx_done while idle, then tx_done coincident with tx_wr
    x_done = 1'b1;
    tick();
    x_done = 1'b0;
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_tx_wr", 32'(tx_wr), 32'd0);
    tick();
    check("idle_done_tx_wr2", 32'(tx_wr), 32'd0);
    dly = 3;
    push_pkt(1, crc_model(1));
    start_pkt(1, 1'b0, 8'h00);
    x_done = 1'b1;
    tick();
    x_done = 1'b0;
    check("coincident_done_no_adv", 32'(tx_wr), 32'd0);
    wait_sent("coincident_done");

    // Reset in the middle of the payload, then a clean packet
    dly = 5;
    for (int i = 0; i < 9; i++) begin
      mem[i] = 8'h31 + 8'(i);
      wr_buf(i, mem[i]);
    end
    push_pkt(9, 8'hA1);
    start_pkt(9, 1'b0, 8'h00);
    repeat (20) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tx_data", 32'(tx_data), 32'd0);
    sb.delete();
    wait_cnt = 0; u_done = 1'b0; last_issued = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (30) tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 9; i++) wr_buf(i, mem[i]);
    push_pkt(9, 8'hA1);
    start_pkt(9, 1'b0, 8'h00);
    wait_sent("post_rst");

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/s3g_packet_tx.md
S3G_PACKET_TX -- requirements
Module: s3g_packet_tx

Interface
REQ-001 The module SHALL have one parameter: MAX_LEN, default 32, the payload buffer depth in bytes (power of two, 2..128).
REQ-002 The module SHALL have these ports, as name / direction / width / meaning:
- clk / in / 1 / system clock; all logic is on the rising edge.
- rst / in / 1 / reset, asynchronous, active-low.
- buf_wr / in / 1 / payload buffer write strobe.
- buf_addr / in / log2(MAX_LEN) / payload buffer write address.
- buf_data / in / 8 / payload buffer write data.
- payload_len / in / 8 / payload length, sampled on packet_wr.
- packet_wr / in / 1 / single-cycle pulse to start sending a packet.
- busy / out / 1 / a packet is in progress.
- packet_sent / out / 1 / single-cycle pulse when the CRC byte has been sent.
- len_err / out / 1 / single-cycle pulse when a request is rejected.
- tx_data / out / 8 / byte to the UART transceiver.
- tx_wr / out / 1 / single-cycle byte write strobe to the UART.
- tx_done / in / 1 / UART pulse: the previous byte has finished.

Function
REQ-003 The module SHALL frame each packet as 0xD5, then the length byte, then the payload bytes in order from buffer address 0, then one CRC byte.
REQ-004 The CRC SHALL be CRC-8/MAXIM, defined as follows:
- Polynomial x^8+x^5+x^4+1, reflected form 0x8C.
- Initial value 0x00, no final XOR.
- Computed over the payload bytes only.
REQ-005 The state machine SHALL use these states: IDLE, SYNC, LEN, PAYLOAD, CRC, FINISH.
REQ-006 In IDLE, packet_wr with payload_len <= MAX_LEN SHALL latch payload_len, clear the CRC to 0x00, set busy, and go to SYNC.
REQ-007 In IDLE, packet_wr with payload_len > MAX_LEN SHALL pulse len_err one cycle later, leave busy low, and send no bytes.
REQ-008 Each of SYNC, LEN, PAYLOAD and CRC SHALL assert tx_wr for exactly one cycle with its byte on tx_data, then wait for tx_done.
REQ-009 tx_data SHALL hold its value from the tx_wr cycle until the next tx_wr.
REQ-010 A packet_wr accepted on cycle N SHALL produce tx_wr carrying 0xD5 on cycle N+1.
REQ-011 tx_done on cycle M SHALL produce the next tx_wr on cycle M+1, with no idle cycle between bytes.
REQ-012 tx_done in SYNC SHALL go to LEN.
REQ-013 tx_done in LEN SHALL go to PAYLOAD if the length is nonzero, otherwise to CRC.
REQ-014 In PAYLOAD, a byte counter SHALL advance on each tx_done and go to CRC after the last byte.
REQ-015 The CRC SHALL be updated with each payload byte as that byte is issued.
REQ-016 Internal buffer read latency SHALL be hidden inside the tx_done-to-tx_wr cycle.
REQ-017 tx_done in CRC SHALL go to FINISH.
REQ-018 FINISH SHALL last one cycle: pulse packet_sent, drop busy, and return to IDLE.
REQ-019 Payload length 0 SHALL send 0xD5 0x00 0x00.
REQ-020 Payload length MAX_LEN SHALL send every buffer entry, and the counter SHALL NOT wrap early.
REQ-021 packet_wr while busy SHALL be ignored and SHALL NOT be queued.
REQ-022 buf_wr while busy SHALL be ignored, so the buffer is frozen during transmission.
REQ-023 buf_wr while idle SHALL write buf_data to buf_addr on that clock edge.
REQ-024 A buf_wr and a packet_wr in the same idle cycle SHALL both take effect, and the written byte SHALL be sent.
REQ-025 tx_done in IDLE or FINISH SHALL be ignored.
REQ-026 A tx_done in the same cycle as tx_wr SHALL NOT count as completion of that byte.
REQ-027 Buffer contents SHALL persist across packets, so resending needs only packet_wr.

Reset
REQ-028 Asserting rst SHALL immediately force the following, including in the middle of a packet:
- State IDLE.
- busy, tx_wr, packet_sent and len_err at 0.
- tx_data at 0x00, byte counter at 0, CRC at 0x00.
REQ-029 After reset no further bytes of an interrupted packet SHALL be sent.
REQ-030 Buffer contents SHALL be undefined after reset and SHALL NOT be cleared by it.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Buffer[0]=0x01, len 1, packet_wr, tx_done 10 cycles after each tx_wr -> bytes D5 01 01 5E, then packet_sent and busy low one cycle after the last tx_done.
- Buffer = 0x31..0x39, len 9 -> D5 09 31 32 33 34 35 36 37 38 39 A1.
- Len 0 -> D5 00 00; len 33 with MAX_LEN 32 -> len_err pulse, no tx_wr, busy stays 0.
- Second packet_wr and a buf_wr to addr 0 of 0xFF, both mid-packet -> exactly one packet sent, and resending the buffer {0x02} gives D5 01 02 BC.
- rst low during the PAYLOAD state -> tx_wr and busy drop at once; after release, a new packet is sent correctly with the CRC restarted.
- tx_done pulses while idle, and tx_done in the same cycle as tx_wr -> no state advance, no extra bytes.
